if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Fetch stage of the 5-stage MIPS pipeline.
- Holds the architectural PC register and consumes the next-PC value produced by the next-PC generator.
- Drives the instruction-memory address and detects fetch address errors (AdEL).
- Contains the IF/ID pipeline register, which feeds PC, instruction, exception code and branch-delay flag to the decode stage.
- Handles stall, exception redirect (Req) and eret delay-slot flush.

Parameters:
RESET_PC, 32'h00003000, PC value after reset
HANDLER_PC, 32'h00004180, exception handler entry
IM_LO, 32'h00003000, lowest legal fetch address
IM_HI, 32'h00006FFC, highest legal fetch address
EXC_ADEL, 5'd4, ExcCode for fetch address error

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
NPC  in  32  next PC from next-PC generator
Stall  in  1  hazard stall: hold PC and IF/ID
Req  in  1  exception/interrupt taken this cycle: redirect to handler
FlushD  in  1  eret in D: squash fetched delay-slot instruction
F_BD  in  1  instruction currently in D is branch/jump, so fetched instr is a delay slot
Instr  in  32  instruction-memory read data for address F_PC
F_PC  out  32  current PC, drives instruction-memory address
D_PC  out  32  IF/ID: PC of instruction in D
D_Instr  out  32  IF/ID: instruction in D
D_ExcCode  out  5  IF/ID: exception code (0 = none)
D_BD  out  1  IF/ID: instruction in D is in a delay slot

Behaviour:
- Reset (async, immediate, any time including mid-stall):
  - F_PC = RESET_PC; D_PC = RESET_PC; D_Instr = 0; D_ExcCode = 0; D_BD = 0.
- PC register, priority per rising edge is reset > Req > Stall > load:
  - Req=1: F_PC <= HANDLER_PC. This holds even when Stall=1, and is independent of NPC.
  - Stall=1: F_PC holds.
  - Otherwise: F_PC <= NPC. NPC is taken verbatim with no alignment correction.
- Fetch check, combinational on F_PC:
  - F_AdEL = (F_PC[1:0] != 0) || F_PC < IM_LO || F_PC > IM_HI, using unsigned compare.
  - F_ExcCode = F_AdEL ? EXC_ADEL : 0.
  - Fetched instruction = F_AdEL ? 32'h0 : Instr. The illegal fetch is converted to a nop carrying the exception.
- IF/ID register, priority per rising edge is reset > Req > Stall > FlushD > load:
  - Req=1: D_Instr <= 0, D_ExcCode <= 0, D_BD <= 0, D_PC <= HANDLER_PC. This keeps a macroscopic PC valid for the bubble.
  - Stall=1: all D_* hold. F_BD is ignored.
  - FlushD=1: D_Instr <= 0, D_ExcCode <= 0, D_BD <= 0, D_PC <= F_PC. The eret has no delay slot.
  - Otherwise: D_PC <= F_PC, D_Instr <= fetched instruction, D_ExcCode <= F_ExcCode, D_BD <= F_BD.
- Latency: one cycle from NPC to F_PC, and one cycle from F_PC/Instr to D_*.
- Instruction memory is combinational read: Instr is valid in the same cycle as F_PC.
- Simultaneous events:
  - Req with Stall: Req wins in both registers.
  - Stall with FlushD: Stall wins. The flush is reapplied when the stall releases, because FlushD is recomputed from D.
- Misaligned PC, e.g. reached via jr:
  - The instruction at that address is never issued.
  - The exception travels downstream with D_BD preserved, so EPC is computed correctly later.
- No wrap handling: any out-of-range PC is simply flagged AdEL.

Decomposition:
- Shared package `mips_defs`: RESET_PC, HANDLER_PC, IM_LO, IM_HI, ExcCode constants (EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12).
- One natural sub-module, `if_id_reg`, containing the IF/ID pipeline register with priority logic.
- PC register and AdEL check stay in the top level.

Test Plan:
- Reset then 3 free cycles with NPC=F_PC+4, Instr=32'h24010001:
  - F_PC goes 3000→3004→3008→300C.
  - D_PC lags F_PC by one cycle.
  - D_Instr=24010001, D_ExcCode=0.
- Stall=1 for 2 cycles at F_PC=3008:
  - F_PC and all D_* hold.
  - On release, F_PC advances to 300C and D_PC=3008.
- NPC=0x00003002 (misaligned jr):
  - Next cycle F_PC=3002.
  - Following edge: D_Instr=0, D_ExcCode=4, D_PC=3002.
- NPC=0x00007000 (out of range), F_BD=1:
  - D_ExcCode=4, D_BD=1, D_Instr=0.
- Req=1 with Stall=1 at F_PC=3010:
  - Next edge: F_PC=4180, D_PC=4180, D_Instr=0, D_ExcCode=0, D_BD=0.
- FlushD=1 at F_PC=3020, NPC=EPC=0x3040:
  - Next edge: D_Instr=0, D_PC=3020, F_PC=3040.
- Assert reset mid-cycle during stall:
  - F_PC=3000 and D_* cleared immediately, without waiting for clk.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: reset/handler vectors, legal fetch window,
// exception codes and the IF/ID payload layout.
package mips_defs;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned EXC_W = 5;

   localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_3000;
   localparam logic [XLEN-1:0] HANDLER_PC = 32'h0000_4180;
   localparam logic [XLEN-1:0] IM_LO      = 32'h0000_3000;
   localparam logic [XLEN-1:0] IM_HI      = 32'h0000_6FFC;

   localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
   localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
   localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
   localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
   localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  instr;
      logic [EXC_W-1:0] exc_code;
      logic             bd;
   } if_id_t;

   // Fetch address error: misaligned or outside the instruction memory window.
   function automatic logic fetch_adel(input logic [XLEN-1:0] pc);
      return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; priority reset > req > stall > flush > load.
module if_id_reg
   import mips_defs::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   stall,
   input  logic   req,
   input  logic   flush,
   input  if_id_t fetch,
   output if_id_t d
);

   if_id_t d_next;

   // A bubble keeps a meaningful PC so downstream EPC logic always has one.
   always_comb begin
      d_next = d;
      if (req) begin
         d_next = '{pc: HANDLER_PC, instr: '0, exc_code: EXC_INT, bd: 1'b0};
      end else if (!stall) begin
         if (flush) begin
            d_next = '{pc: fetch.pc, instr: '0, exc_code: EXC_INT, bd: 1'b0};
         end else begin
            d_next = fetch;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d <= '{pc: RESET_PC, instr: '0, exc_code: EXC_INT, bd: 1'b0};
      end else begin
         d <= d_next;
      end
   end

endmodule

// File: rtl/if_stage.sv
// MIPS fetch stage: PC register, fetch address-error check and IF/ID register.
module if_stage
   import mips_defs::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  NPC,
   input  logic             Stall,
   input  logic             Req,
   input  logic             FlushD,
   input  logic             F_BD,
   input  logic [XLEN-1:0]  Instr,
   output logic [XLEN-1:0]  F_PC,
   output logic [XLEN-1:0]  D_PC,
   output logic [XLEN-1:0]  D_Instr,
   output logic [EXC_W-1:0] D_ExcCode,
   output logic             D_BD
);

   logic   f_adel_c;
   if_id_t fetch_c;
   if_id_t d_q;

   // Redirect to the handler wins over a stall; NPC is taken unaligned.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         F_PC <= RESET_PC;
      end else if (Req) begin
         F_PC <= HANDLER_PC;
      end else if (!Stall) begin
         F_PC <= NPC;
      end
   end

   // An illegal fetch becomes a nop carrying AdEL.
   always_comb begin
      f_adel_c = fetch_adel(F_PC);
      fetch_c  = '{pc: F_PC, instr: Instr, exc_code: EXC_INT, bd: F_BD};
      if (f_adel_c) begin
         fetch_c.instr    = '0;
         fetch_c.exc_code = EXC_ADEL;
      end
   end

   if_id_reg u_if_id_reg (
      .clk   (clk),
      .reset (reset),
      .stall (Stall),
      .req   (Req),
      .flush (FlushD),
      .fetch (fetch_c),
      .d     (d_q)
   );

   assign D_PC      = d_q.pc;
   assign D_Instr   = d_q.instr;
   assign D_ExcCode = d_q.exc_code;
   assign D_BD      = d_q.bd;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_if_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] NPC = '0;
   logic        Stall = 1'b0, Req = 1'b0, FlushD = 1'b0, F_BD = 1'b0;
   logic [31:0] Instr = '0;
   logic [31:0] F_PC, D_PC, D_Instr;
   logic [4:0]  D_ExcCode;
   logic        D_BD;

   int checks = 0;
   int errors = 0;

   // Model state: what the architecturally visible registers must hold.
   logic [31:0] m_fpc = 32'h3000, m_dpc = 32'h3000, m_dinstr = '0;
   logic [4:0]  m_dexc = '0;
   logic        m_dbd = 1'b0;
   bit          rand_instr = 1'b0;

   if_stage dut (
      .clk(clk), .reset(reset), .NPC(NPC), .Stall(Stall), .Req(Req),
      .FlushD(FlushD), .F_BD(F_BD), .Instr(Instr), .F_PC(F_PC), .D_PC(D_PC),
      .D_Instr(D_Instr), .D_ExcCode(D_ExcCode), .D_BD(D_BD)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] pc);
      return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic bit illegal(input logic [31:0] pc);
      return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_fpc = 32'h3000; m_dpc = 32'h3000; m_dinstr = '0; m_dexc = '0; m_dbd = 1'b0;
   endtask

   // Apply one cycle of inputs; model computes the post-edge state from the rules.
   task automatic drive(input logic [31:0] npc, input bit st, input bit rq,
                        input bit fl, input bit bd);
      NPC = npc; Stall = st; Req = rq; FlushD = fl; F_BD = bd;
      Instr = rand_instr ? imem(m_fpc) : 32'h2401_0001;
      if (rq) begin
         m_fpc = 32'h4180;
         m_dpc = 32'h4180; m_dinstr = '0; m_dexc = '0; m_dbd = 1'b0;
      end else if (!st) begin
         if (fl) begin
            m_dpc = m_fpc; m_dinstr = '0; m_dexc = '0; m_dbd = 1'b0;
         end else begin
            m_dpc    = m_fpc;
            m_dinstr = illegal(m_fpc) ? 32'h0 : Instr;
            m_dexc   = illegal(m_fpc) ? 5'd4 : 5'd0;
            m_dbd    = bd;
         end
         m_fpc = npc;
      end
      @(negedge clk);
   endtask

   // Continuous comparison shortly after each rising edge.
   always @(posedge clk) begin
      #2;
      chk("cyc_F_PC", F_PC, m_fpc);
      chk("cyc_D_PC", D_PC, m_dpc);
      chk("cyc_D_Instr", D_Instr, m_dinstr);
      chk("cyc_D_ExcCode", 32'(D_ExcCode), 32'(m_dexc));
      chk("cyc_D_BD", 32'(D_BD), 32'(m_dbd));
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_F_PC", F_PC, 32'h3000);
      chk("rst_D_PC", D_PC, 32'h3000);
      chk("rst_D_Instr", D_Instr, 32'h0);
      chk("rst_D_Exc", 32'(D_ExcCode), 32'h0);
      chk("rst_D_BD", 32'(D_BD), 32'h0);
      reset = 1'b0;

      drive(32'h3004, 0, 0, 0, 0);
      chk("run_F_PC1", F_PC, 32'h3004);
      chk("run_D_PC1", D_PC, 32'h3000);
      chk("run_D_Instr1", D_Instr, 32'h2401_0001);
      drive(32'h3008, 0, 0, 0, 0);
      drive(32'h300C, 1, 0, 0, 0);
      drive(32'h300C, 1, 0, 0, 0);
      chk("stall_F_PC", F_PC, 32'h3008);
      chk("stall_D_PC", D_PC, 32'h3004);
      drive(32'h300C, 0, 0, 0, 0);
      chk("release_F_PC", F_PC, 32'h300C);
      chk("release_D_PC", D_PC, 32'h3008);

      drive(32'h3002, 0, 0, 0, 0);
      chk("misal_F_PC", F_PC, 32'h3002);
      drive(32'h3006, 0, 0, 0, 0);
      chk("misal_D_Instr", D_Instr, 32'h0);
      chk("misal_D_Exc", 32'(D_ExcCode), 32'd4);
      chk("misal_D_PC", D_PC, 32'h3002);

      drive(32'h7000, 0, 0, 0, 0);
      drive(32'h3010, 0, 0, 0, 1);
      chk("oor_D_PC", D_PC, 32'h7000);
      chk("oor_D_Exc", 32'(D_ExcCode), 32'd4);
      chk("oor_D_BD", 32'(D_BD), 32'd1);
      chk("oor_D_Instr", D_Instr, 32'h0);

      drive(32'h3014, 1, 1, 0, 1);
      chk("req_F_PC", F_PC, 32'h4180);
      chk("req_D_PC", D_PC, 32'h4180);
      chk("req_D_Instr", D_Instr, 32'h0);
      chk("req_D_Exc", 32'(D_ExcCode), 32'h0);
      chk("req_D_BD", 32'(D_BD), 32'h0);

      drive(32'h3020, 0, 0, 0, 0);
      drive(32'h3040, 0, 0, 1, 1);
      chk("flush_D_Instr", D_Instr, 32'h0);
      chk("flush_D_PC", D_PC, 32'h3020);
      chk("flush_F_PC", F_PC, 32'h3040);

      drive(32'h3044, 1, 0, 0, 0);
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("async_F_PC", F_PC, 32'h3000);
      chk("async_D_PC", D_PC, 32'h3000);
      chk("async_D_Instr", D_Instr, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      rand_instr = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] npc;
         int unsigned sel;
         sel = $urandom_range(99);
         if (sel < 50)      npc = m_fpc + 32'd4;
         else if (sel < 70) npc = 32'h3000 + {18'd0, 12'($urandom_range(4095)), 2'b00};
         else if (sel < 80) npc = m_fpc + 32'($urandom_range(1, 3));
         else if (sel < 90) npc = $urandom;
         else               npc = 32'h6FF8 + 32'($urandom_range(3) * 4);
         drive(npc, $urandom_range(99) < 20, $urandom_range(99) < 5,
               $urandom_range(99) < 10, $urandom_range(99) < 30);
         if ($urandom_range(199) == 0) begin
            #2 reset = 1'b1;
            model_reset();
            @(negedge clk);
            reset = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
